// File: rtl/temp_avg_filter.sv
// Sliding-window mean of signed temperature samples with a hysteresis over-temperature alarm.
// Two-stage pipeline: capture sample/evicted entry, update running sum, then register mean and alarm.
module temp_avg_filter #(
    parameter int                 DEPTH_LOG2 = 3,
    parameter logic signed [15:0] HI_THRESH  = 16'sh1900,
    parameter logic signed [15:0] LO_THRESH  = 16'sh1800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        din_valid,
    input  logic        clear,
    output logic [15:0] avg,
    output logic        avg_valid,
    output logic [7:0]  avg_byte,
    output logic        full,
    output logic        alarm
);
    localparam int N     = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int SUM_W = 16 + DEPTH_LOG2;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    logic [15:0]             mem_q [N];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;

    // Stage 1: accepted sample, the entry it evicts, and whether it produces an output.
    logic                    s1_valid_q, s1_valid_d;
    logic signed [15:0]      s1_din_q, s1_din_d;
    logic signed [15:0]      s1_old_q, s1_old_d;
    logic                    s1_sub_q, s1_sub_d;
    logic                    s1_emit_q, s1_emit_d;
    logic                    s2_valid_q, s2_valid_d;

    logic signed [15:0]      avg_q, avg_d;
    logic                    avg_valid_q, avg_valid_d;
    logic                    alarm_q, alarm_d;

    logic                    accept;
    logic signed [SUM_W-1:0] sub_val;
    logic signed [15:0]      new_avg;

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [15:0] x);
        return {{DEPTH_LOG2{x[15]}}, x};
    endfunction

    assign accept  = din_valid && !clear;
    assign sub_val = s1_sub_q ? sext(s1_old_q) : '0;
    assign new_avg = 16'(sum_q >>> DEPTH_LOG2);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        alarm_d     = alarm_q;
        s1_valid_d  = accept;
        s1_din_d    = din;
        s1_old_d    = mem_q[wr_ptr_q];
        s1_sub_d    = (cnt_q == N_CNT);
        s1_emit_d   = (cnt_q >= N_CNT - CNT_W'(1));
        s2_valid_d  = s1_valid_q && s1_emit_q;
        avg_valid_d = s2_valid_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (cnt_q != N_CNT) cnt_d = cnt_q + CNT_W'(1);
        end

        if (s1_valid_q) sum_d = sum_q + sext(s1_din_q) - sub_val;

        if (s2_valid_q) begin
            avg_d = new_avg;
            if (new_avg > HI_THRESH)      alarm_d = 1'b1;
            else if (new_avg < LO_THRESH) alarm_d = 1'b0;
        end

        // Flush: in-flight results are discarded, avg keeps its last value.
        if (clear) begin
            wr_ptr_d    = '0;
            cnt_d       = '0;
            sum_d       = '0;
            alarm_d     = 1'b0;
            avg_d       = avg_q;
            s2_valid_d  = 1'b0;
            avg_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_din_q    <= '0;
            s1_old_q    <= '0;
            s1_sub_q    <= 1'b0;
            s1_emit_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            s1_valid_q  <= s1_valid_d;
            s1_din_q    <= s1_din_d;
            s1_old_q    <= s1_old_d;
            s1_sub_q    <= s1_sub_d;
            s1_emit_q   <= s1_emit_d;
            s2_valid_q  <= s2_valid_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            alarm_q     <= alarm_d;
        end
    end

    // NOTE: the window RAM is deliberately not reset; cnt gating keeps stale entries out of the sum.
    always_ff @(posedge clk) begin
        if (accept && !reset) mem_q[wr_ptr_q] <= din;
    end

    assign avg       = avg_q;
    assign avg_valid = avg_valid_q;
    assign avg_byte  = avg_q[15:8];
    assign full      = (cnt_q == N_CNT);
    assign alarm     = alarm_q;
endmodule

// File: tb/tb_temp_avg_filter.sv
// Scoreboard bench for temp_avg_filter: a window model predicts each mean/alarm when the sample is driven.
module tb_temp_avg_filter;
    localparam int D = 3;
    localparam int N = 8;
    localparam logic signed [15:0] HI = 16'sh1900;
    localparam logic signed [15:0] LO = 16'sh1800;

    logic        clk = 1'b0;
    logic        reset, din_valid, clear;
    logic [15:0] din;
    logic [15:0] avg;
    logic        avg_valid, full, alarm;
    logic [7:0]  avg_byte;

    typedef struct {
        logic [15:0] avg;
        logic        alarm;
        int          due;
    } exp_t;

    exp_t q[$];
    int   win[$];
    logic m_alarm = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;

    temp_avg_filter #(.DEPTH_LOG2(D), .HI_THRESH(HI), .LO_THRESH(LO)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .avg(avg), .avg_valid(avg_valid), .avg_byte(avg_byte), .full(full), .alarm(alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model for this edge, then compare what the DUT shows.
    task automatic step(input logic v, input logic [15:0] d, input logic c, input logic r);
        int          s;
        logic [15:0] a;
        exp_t        e;
        reset = r; din_valid = v; din = d; clear = c;
        @(posedge clk);
        #1;
        cyc++;
        if (r || c) begin
            q.delete();
            win.delete();
            m_alarm = 1'b0;
        end else if (v) begin
            win.push_back(int'($signed(d)));
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) begin
                s = 0;
                foreach (win[i]) s += win[i];
                a = 16'(s >>> D);
                if ($signed(a) > HI)      m_alarm = 1'b1;
                else if ($signed(a) < LO) m_alarm = 1'b0;
                q.push_back('{avg: a, alarm: m_alarm, due: cyc + 2});
            end
        end
        check("full", 32'(full), 32'(win.size() == N));
        if (avg_valid) begin
            pulses++;
            if (q.size() == 0) begin
                check("avg_valid_spurious", 32'(avg_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("latency", 32'(cyc), 32'(e.due));
                check("avg", 32'(avg), 32'(e.avg));
                check("avg_byte", 32'(avg_byte), 32'(e.avg[15:8]));
                check("alarm", 32'(alarm), 32'(e.alarm));
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            check("avg_valid_missing", 32'(avg_valid), 32'd1);
            void'(q.pop_front());
        end
        if (r) begin
            check("rst_avg", 32'(avg), 32'd0);
            check("rst_alarm", 32'(alarm), 32'd0);
        end
        if (c && !r) check("clr_alarm", 32'(alarm), 32'd0);
    endtask

    task automatic feed(input int count, input logic [15:0] d);
        for (int i = 0; i < count; i++) step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int count);
        for (int i = 0; i < count; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h7FFF, 1'b1, 1'b1);
    endtask

    initial begin
        reset = 1'b1; din_valid = 1'b0; clear = 1'b0; din = '0;
        do_reset();

        // Fill with 0x0100.
        pulses = 0;
        feed(7, 16'h0100);
        check("fill_no_pulse", 32'(pulses), 32'd0);
        feed(1, 16'h0100);
        idle(2);
        check("fill_avg", 32'(avg), 32'h0100);
        check("fill_byte", 32'(avg_byte), 32'h01);
        check("fill_alarm", 32'(alarm), 32'd0);

        // Negative samples push the mean through zero and below.
        feed(4, 16'hFF00);
        idle(2);
        check("wrap_avg0", 32'(avg), 32'h0000);
        feed(4, 16'hFF00);
        idle(2);
        check("wrap_avg_neg", 32'(avg), 32'hFF00);
        check("wrap_byte", 32'(avg_byte), 32'hFF);

        // Hysteresis.
        do_reset();
        feed(8, 16'h1A00);
        idle(2);
        check("hyst_set", 32'(alarm), 32'd1);
        feed(8, 16'h1880);
        idle(2);
        check("hyst_hold", 32'(alarm), 32'd1);
        feed(8, 16'h1700);
        idle(2);
        check("hyst_clear", 32'(alarm), 32'd0);

        // Back-to-back ramp.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        idle(2);
        check("ramp_pulses", 32'(pulses), 32'd9);
        check("ramp_avg", 32'(avg), 32'h000B);

        // Clear colliding with a sample.
        do_reset();
        feed(5, 16'h0200);
        step(1'b1, 16'h7000, 1'b1, 1'b0);
        pulses = 0;
        feed(7, 16'h0300);
        idle(2);
        check("clr_no_pulse", 32'(pulses), 32'd0);
        feed(1, 16'h0300);
        idle(2);
        check("clr_pulse", 32'(pulses), 32'd1);
        check("clr_avg", 32'(avg), 32'h0300);

        // Reset with alarm set and samples in flight.
        do_reset();
        feed(10, 16'h1A00);
        check("pre_rst_alarm", 32'(alarm), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(avg_valid), 32'd0);
        pulses = 0;
        feed(7, 16'h0100);
        check("rst_no_pulse", 32'(pulses), 32'd0);
        feed(1, 16'h0100);
        idle(2);
        check("rst_pulse", 32'(pulses), 32'd1);

        // Random traffic with occasional clears.
        do_reset();
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom_range(16'h1600, 16'h1B00)),
                 $urandom_range(0, 39) == 0, 1'b0);
        idle(3);
        check("drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
